lze_frame_sched: RTL and testbench
==================================

Name: lze_frame_sched

Overview:
- Round-robin scheduler that shares one LZ77 encoder core between NUM_REQ frame sources.
- Per frame: grants one requester, pulses the encoder's active-high reset, streams the frame bytes into it, collects the emitted (offset, match_len, char_nxt) triples, tags each with the requester id, and flags frame end and errors.
- Sits between the source byte FIFOs and the encoder core; owns the encoder's reset, code_valid and chardata.

Parameters:
- NUM_REQ, 2, number of requesters (2..4); ID_W = clog2(NUM_REQ), minimum 1.
- MAX_LEN, 30, maximum frame length in bytes (encoder buffer depth).
- RST_CYC, 2, cycles enc_reset is held high before each frame.
- WDOG, 255, max idle cycles in WAIT with no triple before abort.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  frame request per source; held until grant
- req_len  in  NUM_REQ*5  frame length per source (slice i = bits 5i+4:5i)
- grant  out  NUM_REQ  one-hot; high from LOAD entry through DONE
- src_rd  out  1  pop strobe to the granted source
- src_data  in  NUM_REQ*8  show-ahead data per source; valid in the same cycle as src_rd
- enc_reset  out  1  active-high reset to the encoder core
- code_valid  out  1  encoder load strobe
- chardata  out  8  encoder load byte
- enc_valid  in  1  encoder triple valid
- enc_encode  in  1  encoder encode flag; a triple counts only when enc_valid and enc_encode are both high
- enc_offset  in  4  triple offset
- enc_match_len  in  4  triple match length
- enc_char_nxt  in  8  triple next char
- out_valid  out  1  tagged triple valid (1-cycle pulse)
- out_id  out  ID_W  owner of the triple
- out_offset  out  4  registered copy of enc_offset
- out_match_len  out  4  registered copy of enc_match_len
- out_char_nxt  out  8  registered copy of enc_char_nxt
- out_last  out  1  triple completes the frame
- frame_done  out  1  1-cycle pulse at DONE
- err  out  1  1-cycle pulse: bad length, watchdog timeout or overshoot

Behaviour:
- Reset values: all outputs 0 except enc_reset = 1; state IDLE; rr_ptr = 0; counters 0.
- IDLE:
  - If any req is set, pick the first set bit at or after rr_ptr (wrapping).
  - Latch id and len; go to CHK. No request: stay, enc_reset stays 1.
- CHK:
  - len == 0 or len > MAX_LEN: err pulse, rr_ptr = id+1 mod NUM_REQ, back to IDLE.
  - Otherwise: rst_cnt = 0, go to RST.
- RST:
  - enc_reset = 1 for RST_CYC cycles.
  - On exit, enc_reset drops in the same cycle LOAD begins.
  - LOAD must drive code_valid in the first cycle after enc_reset deasserts, because the encoder leaves its load state on the first low code_valid.
- LOAD:
  - grant[id] = 1; src_rd = code_valid = 1; chardata = src_data[id].
  - One byte per cycle for exactly len cycles, with no gaps; load_cnt counts 0..len-1.
  - After the last byte, code_valid = 0 and go to WAIT.
- WAIT:
  - On each enc_valid & enc_encode: register the triple onto out_* with out_valid = 1 and out_id = id.
  - cons += match_len + 1 (6-bit arithmetic); wdog resets to 0.
  - If the new cons == len: out_last = 1, go to DONE.
  - If the new cons > len: err pulse, out_last = 1, go to DONE.
  - If wdog reaches WDOG: err pulse, go to DONE with no out_last.
- DONE:
  - frame_done = 1, grant drops, enc_reset = 1.
  - rr_ptr = id+1 mod NUM_REQ; go to IDLE.
- Arbitration:
  - Requests are sampled only in IDLE; req changes during a frame are ignored.
  - Simultaneous requests are resolved by rr_ptr, so two always-on sources alternate A,B,A,B.
- enc_reset is 1 in IDLE, CHK, RST and DONE; 0 in LOAD and WAIT.
- Latency: out_valid is one cycle after the encoder's valid (registered); frame_done is one cycle after out_last.
- Reset asserted mid-frame: everything returns to reset values immediately; the granted source must flush its partial frame.

Decomposition:
- Shared package lze_pkg:
  - State enum: IDLE, CHK, RST, LOAD, WAIT, DONE.
  - LZE_MAX_LEN = 30, LZE_LEN_W = 5, LZE_SEARCH_LEN = 9, LZE_LOOKAHEAD_LEN = 8.
  - Triple struct: offset[3:0], match_len[3:0], char_nxt[7:0].
- One sub-module: lze_rr_arb (NUM_REQ-wide round-robin picker; inputs req and rr_ptr; outputs one-hot gnt and any).

Test Plan:
- Single frame: source 0, len 5, bytes "AAAAB"; stub encoder returns (0,0,'A'), (0,3,'B') → 5 bytes on chardata with code_valid high 5 consecutive cycles right after enc_reset falls; two out_valid pulses with out_id = 0; out_last on the second; frame_done one cycle later.
- Contention: req = 2'b11 held, both len 3 → grants in order 0,1,0; enc_reset pulses RST_CYC cycles between frames; no out_valid overlaps a grant change.
- Bad length: req_len = 0, then a separate frame with req_len = 31 → err pulse each time; grant never set; rr_ptr advances; next request is served normally.
- Overshoot: len 4; encoder returns match_len 4 on its first triple (cons = 5) → out_last = 1, err = 1 and frame_done all asserted in the expected cycles.
- Watchdog: WDOG = 10; encoder silent after load → err at WAIT cycle 10, then frame_done, back to IDLE, enc_reset = 1.
- Async reset asserted at the 3rd LOAD cycle → grant, code_valid and src_rd = 0 and enc_reset = 1 without waiting for a clock edge; a fresh frame completes correctly after release.

Source files
------------

// File: rtl/lze_pkg.sv
// Shared types and constants for the LZ77 frame scheduler.
package lze_pkg;

  localparam int LZE_MAX_LEN       = 30;
  localparam int LZE_LEN_W         = 5;
  localparam int LZE_SEARCH_LEN    = 9;
  localparam int LZE_LOOKAHEAD_LEN = 8;

  // Scheduler FSM states, one frame per pass IDLE -> ... -> DONE.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CHK  = 3'd1,
    RST  = 3'd2,
    LOAD = 3'd3,
    WAIT = 3'd4,
    DONE = 3'd5
  } lze_state_t;

  // One encoder output triple.
  typedef struct packed {
    logic [3:0] offset;
    logic [3:0] match_len;
    logic [7:0] char_nxt;
  } lze_triple_t;

endpackage

// File: rtl/lze_rr_arb.sv
// Round-robin picker: grants the first set request at or after rr_ptr, wrapping.
module lze_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               any
);

  // Scan from rr_ptr upwards and keep only the first hit.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    idx = 0;
    gnt = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lze_frame_sched.sv
// Shares one LZ77 encoder core between NUM_REQ frame sources, one frame at a time.
module lze_frame_sched
  import lze_pkg::*;
#(
  parameter int  NUM_REQ = 2,
  parameter int  MAX_LEN = LZE_MAX_LEN,
  parameter int  RST_CYC = 2,
  parameter int  WDOG    = 255,
  localparam int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*LZE_LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         src_rd,
  input  logic [NUM_REQ*8-1:0]         src_data,
  output logic                         enc_reset,
  output logic                         code_valid,
  output logic [7:0]                   chardata,
  input  logic                         enc_valid,
  input  logic                         enc_encode,
  input  logic [3:0]                   enc_offset,
  input  logic [3:0]                   enc_match_len,
  input  logic [7:0]                   enc_char_nxt,
  output logic                         out_valid,
  output logic [ID_W-1:0]              out_id,
  output logic [3:0]                   out_offset,
  output logic [3:0]                   out_match_len,
  output logic [7:0]                   out_char_nxt,
  output logic                         out_last,
  output logic                         frame_done,
  output logic                         err
);

  localparam int WD_W = $clog2(WDOG + 1);
  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  lze_state_t           state;
  logic [ID_W-1:0]      id;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      pick_id;
  logic [ID_W-1:0]      id_inc;
  logic [LZE_LEN_W-1:0] len;
  logic [LZE_LEN_W-1:0] pick_len;
  logic [LZE_LEN_W-1:0] load_cnt;
  logic [5:0]           cons;
  logic [5:0]           cons_nxt;
  logic [WD_W-1:0]      wdog;
  logic [RC_W-1:0]      rst_cnt;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic                 arb_any;
  logic [7:0]           sel_byte;
  logic                 hit;
  lze_triple_t          out_q;

  lze_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .any    (arb_any)
  );

  // Encode the one-hot pick to an index and fetch that source's length.
  always_comb begin
    pick_id  = '0;
    pick_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        pick_id  = ID_W'(i);
        pick_len = req_len[i*LZE_LEN_W +: LZE_LEN_W];
      end
    end
  end

  // Show-ahead byte of the granted source and the wrapped successor of id.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(id) == i) sel_byte = src_data[i*8 +: 8];
    end
    id_inc = (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
  end

  assign hit      = enc_valid & enc_encode;
  assign cons_nxt = cons + 6'(enc_match_len) + 6'd1;

  // Encoder-side controls decode straight from state so an async reset clears them at once.
  always_comb begin
    grant = '0;
    if (state == LOAD || state == WAIT || state == DONE) grant[id] = 1'b1;
    code_valid = (state == LOAD);
    src_rd     = code_valid;
    chardata   = code_valid ? sel_byte : 8'd0;
    enc_reset  = !(state == LOAD || state == WAIT);
  end

  assign out_offset    = out_q.offset;
  assign out_match_len = out_q.match_len;
  assign out_char_nxt  = out_q.char_nxt;

  // Frame FSM: arbitrate, check length, reset encoder, load bytes, collect triples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      id         <= '0;
      rr_ptr     <= '0;
      len        <= '0;
      load_cnt   <= '0;
      cons       <= '0;
      wdog       <= '0;
      rst_cnt    <= '0;
      out_valid  <= 1'b0;
      out_id     <= '0;
      out_q      <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every branch reads pre-edge values; pulses default low here.
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            id    <= pick_id;
            len   <= pick_len;
            state <= CHK;
          end
        end
        CHK: begin
          if (len == '0 || int'(len) > MAX_LEN) begin
            err    <= 1'b1;
            rr_ptr <= id_inc;
            state  <= IDLE;
          end else begin
            rst_cnt <= '0;
            state   <= RST;
          end
        end
        RST: begin
          if (int'(rst_cnt) == RST_CYC - 1) begin
            load_cnt <= '0;
            state    <= LOAD;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        LOAD: begin
          if (load_cnt == len - 1'b1) begin
            cons  <= '0;
            wdog  <= '0;
            state <= WAIT;
          end else begin
            load_cnt <= load_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (hit) begin
            out_valid <= 1'b1;
            out_id    <= id;
            out_q     <= '{offset: enc_offset, match_len: enc_match_len, char_nxt: enc_char_nxt};
            cons      <= cons_nxt;
            wdog      <= '0;
            if (cons_nxt >= 6'(len)) begin
              out_last <= 1'b1;
              err      <= (cons_nxt != 6'(len));
              state    <= DONE;
            end
          end else if (int'(wdog) == WDOG - 1) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          rr_ptr     <= id_inc;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lze_frame_sched.sv
// Directed bench for lze_frame_sched with a hand-driven stub encoder and source.
module tb_lze_frame_sched;

  localparam int NR = 2;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [9:0]  req_len;
  logic [1:0]  grant;
  logic        src_rd;
  logic [15:0] src_data;
  logic        enc_reset;
  logic        code_valid;
  logic [7:0]  chardata;
  logic        enc_valid;
  logic        enc_encode;
  logic [3:0]  enc_offset;
  logic [3:0]  enc_match_len;
  logic [7:0]  enc_char_nxt;
  logic        out_valid;
  logic [0:0]  out_id;
  logic [3:0]  out_offset;
  logic [3:0]  out_match_len;
  logic [7:0]  out_char_nxt;
  logic        out_last;
  logic        frame_done;
  logic        err;

  int passed = 0;
  int total  = 0;
  logic [7:0] fbytes [0:47];

  lze_frame_sched #(
    .NUM_REQ (2),
    .MAX_LEN (30),
    .RST_CYC (2),
    .WDOG    (10)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_len       (req_len),
    .grant         (grant),
    .src_rd        (src_rd),
    .src_data      (src_data),
    .enc_reset     (enc_reset),
    .code_valid    (code_valid),
    .chardata      (chardata),
    .enc_valid     (enc_valid),
    .enc_encode    (enc_encode),
    .enc_offset    (enc_offset),
    .enc_match_len (enc_match_len),
    .enc_char_nxt  (enc_char_nxt),
    .out_valid     (out_valid),
    .out_id        (out_id),
    .out_offset    (out_offset),
    .out_match_len (out_match_len),
    .out_char_nxt  (out_char_nxt),
    .out_last      (out_last),
    .frame_done    (frame_done),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req   = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic fill_bytes(input logic [7:0] base);
    for (int k = 0; k < 48; k++) fbytes[k] = base + 8'(k);
  endtask

  // Waits for the load window, feeding fbytes as show-ahead data; returns observations.
  task automatic do_load(input int src, output int pre_hi, output int got, output int bad,
                         output logic [1:0] first_gnt);
    pre_hi    = 0;
    got       = 0;
    bad       = 0;
    first_gnt = '0;
    src_data[src*8 +: 8] = fbytes[0];
    for (int c = 0; c < 40; c++) begin
      step();
      if (code_valid) break;
      if (enc_reset) pre_hi++;
    end
    first_gnt = grant;
    for (int k = 0; k < 40 && code_valid; k++) begin
      if (!src_rd || enc_reset || chardata !== fbytes[k] || grant !== (2'b01 << src)) bad++;
      got++;
      src_data[src*8 +: 8] = fbytes[k+1];
      step();
    end
  endtask

  task automatic send_triple(input logic [3:0] off, input logic [3:0] ml, input logic [7:0] ch);
    enc_valid     = 1'b1;
    enc_encode    = 1'b1;
    enc_offset    = off;
    enc_match_len = ml;
    enc_char_nxt  = ch;
    step();
    enc_valid  = 1'b0;
    enc_encode = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = '0; req_len = '0; src_data = '0;
    enc_valid = 1'b0; enc_encode = 1'b0;
    enc_offset = '0; enc_match_len = '0; enc_char_nxt = '0;
    #3;
    total++; if (enc_reset !== 1'b1) $display("FAIL reset_enc_reset: got %b want 1", enc_reset); else passed++;
    total++; if ({grant, src_rd, code_valid, chardata} !== 12'd0)
      $display("FAIL reset_load_ctl: got %h want 000", {grant, src_rd, code_valid, chardata}); else passed++;
    total++; if ({out_valid, out_id, out_last, frame_done, err} !== 5'd0)
      $display("FAIL reset_pulses: got %b want 00000", {out_valid, out_id, out_last, frame_done, err}); else passed++;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_single();
    int pre, got, bad;
    logic [1:0] fg;
    fbytes[0] = "A"; fbytes[1] = "A"; fbytes[2] = "A"; fbytes[3] = "A"; fbytes[4] = "B"; fbytes[5] = 8'h00;
    req_len[4:0] = 5'd5;
    req = 2'b01;
    do_load(0, pre, got, bad, fg);
    req = 2'b00;
    total++; if (pre !== 3) $display("FAIL single_enc_reset_cycles: got %0d want 3", pre); else passed++;
    total++; if (got !== 5) $display("FAIL single_load_cycles: got %0d want 5", got); else passed++;
    total++; if (bad !== 0) $display("FAIL single_load_bytes: got %0d bad want 0", bad); else passed++;
    enc_valid = 1'b1;
    enc_encode = 1'b0;
    step();
    enc_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL single_no_encode: got %b want 0", out_valid); else passed++;
    send_triple(4'd0, 4'd0, "A");
    total++; if ({out_valid, out_id, out_last, out_char_nxt} !== {1'b1, 1'b0, 1'b0, 8'h41})
      $display("FAIL single_triple1: got %h want 141", {out_valid, out_id, out_last, out_char_nxt}); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL single_pulse_width: got %b want 0", out_valid); else passed++;
    send_triple(4'd0, 4'd3, "B");
    total++; if ({out_valid, out_last, out_match_len, out_char_nxt, err, frame_done} !== {1'b1, 1'b1, 4'd3, 8'h42, 1'b0, 1'b0})
      $display("FAIL single_triple2: got %h want %h", {out_valid, out_last, out_match_len, out_char_nxt, err, frame_done},
               {1'b1, 1'b1, 4'd3, 8'h42, 1'b0, 1'b0}); else passed++;
    total++; if (grant !== 2'b01) $display("FAIL single_grant_done: got %b want 01", grant); else passed++;
    step();
    total++; if ({frame_done, grant, enc_reset, out_last} !== 5'b10010)
      $display("FAIL single_frame_done: got %b want 10010", {frame_done, grant, enc_reset, out_last}); else passed++;
  endtask

  task automatic test_contention();
    int pre, got, bad;
    logic [1:0] fg;
    apply_reset();
    req_len = {5'd3, 5'd3};
    req = 2'b11;
    for (int f = 0; f < 3; f++) begin
      fill_bytes(8'(16 * (f + 1)));
      do_load(f % 2, pre, got, bad, fg);
      if (f == 2) req = 2'b00;
      total++; if (fg !== (2'b01 << (f % 2))) $display("FAIL contention_grant_%0d: got %b want %b", f, fg, 2'b01 << (f % 2)); else passed++;
      total++; if (pre !== 3 || got !== 3 || bad !== 0)
        $display("FAIL contention_load_%0d: got pre=%0d len=%0d bad=%0d want 3 3 0", f, pre, got, bad); else passed++;
      send_triple(4'd1, 4'd2, 8'(8'h50 + f));
      total++; if ({out_valid, out_last, out_id, grant} !== {1'b1, 1'b1, 1'(f % 2), 2'b01 << (f % 2)})
        $display("FAIL contention_out_%0d: got %b want %b", f, {out_valid, out_last, out_id, grant},
                 {1'b1, 1'b1, 1'(f % 2), 2'b01 << (f % 2)}); else passed++;
      step();
      total++; if ({frame_done, grant} !== 3'b100) $display("FAIL contention_done_%0d: got %b want 100", f, {frame_done, grant}); else passed++;
    end
  endtask

  task automatic test_bad_len();
    int pre, got, bad;
    logic [1:0] fg;
    logic [1:0] gseen;
    apply_reset();
    gseen = '0;
    req_len = {5'd0, 5'd0};
    req = 2'b01;
    step();
    gseen |= grant;
    step();
    gseen |= grant;
    total++; if (err !== 1'b1) $display("FAIL bad_len_zero_err: got %b want 1", err); else passed++;
    req_len = {5'd31, 5'd2};
    req = 2'b11;
    step();
    gseen |= grant;
    total++; if (err !== 1'b0) $display("FAIL bad_len_err_pulse: got %b want 0", err); else passed++;
    step();
    gseen |= grant;
    total++; if (err !== 1'b1) $display("FAIL bad_len_31_err: got %b want 1", err); else passed++;
    total++; if (gseen !== 2'b00) $display("FAIL bad_len_grant: got %b want 00", gseen); else passed++;
    fill_bytes(8'h70);
    do_load(0, pre, got, bad, fg);
    req = 2'b00;
    total++; if (fg !== 2'b01 || got !== 2 || bad !== 0)
      $display("FAIL bad_len_next_frame: got gnt=%b len=%0d bad=%0d want 01 2 0", fg, got, bad); else passed++;
    send_triple(4'd0, 4'd1, "z");
    total++; if ({out_valid, out_last, out_id, err} !== 4'b1100)
      $display("FAIL bad_len_next_out: got %b want 1100", {out_valid, out_last, out_id, err}); else passed++;
    step();
    total++; if (frame_done !== 1'b1) $display("FAIL bad_len_next_done: got %b want 1", frame_done); else passed++;
  endtask

  task automatic test_overshoot();
    int pre, got, bad;
    logic [1:0] fg;
    req_len = {5'd4, 5'd0};
    req = 2'b10;
    fill_bytes(8'h20);
    do_load(1, pre, got, bad, fg);
    req = 2'b00;
    total++; if (fg !== 2'b10 || got !== 4 || bad !== 0)
      $display("FAIL overshoot_load: got gnt=%b len=%0d bad=%0d want 10 4 0", fg, got, bad); else passed++;
    send_triple(4'd2, 4'd4, "q");
    total++; if ({out_valid, out_last, err, frame_done, out_id, out_match_len} !== {4'b1110, 1'b1, 4'd4})
      $display("FAIL overshoot_out: got %b want %b", {out_valid, out_last, err, frame_done, out_id, out_match_len},
               {4'b1110, 1'b1, 4'd4}); else passed++;
    step();
    total++; if ({frame_done, err, out_valid} !== 3'b100)
      $display("FAIL overshoot_done: got %b want 100", {frame_done, err, out_valid}); else passed++;
  endtask

  task automatic test_watchdog();
    int pre, got, bad, n;
    logic [1:0] fg;
    req_len = {5'd0, 5'd6};
    req = 2'b01;
    fill_bytes(8'h30);
    do_load(0, pre, got, bad, fg);
    req = 2'b00;
    total++; if (got !== 6 || enc_reset !== 1'b0)
      $display("FAIL wdog_load: got len=%0d enc_reset=%b want 6 0", got, enc_reset); else passed++;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (err) break;
      step();
      n++;
    end
    total++; if (n !== 10) $display("FAIL wdog_cycles: got %0d want 10", n); else passed++;
    total++; if ({err, out_last, out_valid, enc_reset, grant, frame_done} !== 7'b1001010)
      $display("FAIL wdog_abort: got %b want 1001010", {err, out_last, out_valid, enc_reset, grant, frame_done}); else passed++;
    step();
    total++; if ({frame_done, grant, enc_reset, err} !== 5'b10010)
      $display("FAIL wdog_done: got %b want 10010", {frame_done, grant, enc_reset, err}); else passed++;
  endtask

  task automatic test_async_reset();
    int pre, got, bad;
    logic [1:0] fg;
    req_len = {5'd0, 5'd6};
    req = 2'b01;
    fill_bytes(8'h40);
    src_data[7:0] = fbytes[0];
    for (int c = 0; c < 40; c++) begin
      step();
      if (code_valid) break;
    end
    step();
    step();
    total++; if ({code_valid, grant} !== 3'b101) $display("FAIL arst_third_load: got %b want 101", {code_valid, grant}); else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++; if ({grant, code_valid, src_rd, enc_reset} !== 5'b00001)
      $display("FAIL arst_immediate: got %b want 00001", {grant, code_valid, src_rd, enc_reset}); else passed++;
    req = 2'b00;
    step();
    step();
    reset = 1'b1;
    req_len = {5'd0, 5'd3};
    req = 2'b01;
    fill_bytes(8'h60);
    do_load(0, pre, got, bad, fg);
    req = 2'b00;
    total++; if (pre !== 3 || got !== 3 || bad !== 0 || fg !== 2'b01)
      $display("FAIL arst_fresh_load: got pre=%0d len=%0d bad=%0d gnt=%b want 3 3 0 01", pre, got, bad, fg); else passed++;
    send_triple(4'd1, 4'd2, "k");
    total++; if ({out_valid, out_last, out_offset, err} !== {1'b1, 1'b1, 4'd1, 1'b0})
      $display("FAIL arst_fresh_out: got %b want %b", {out_valid, out_last, out_offset, err}, {1'b1, 1'b1, 4'd1, 1'b0}); else passed++;
    step();
    total++; if (frame_done !== 1'b1) $display("FAIL arst_fresh_done: got %b want 1", frame_done); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_bad_len();
    test_overshoot();
    test_watchdog();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
